axi_read_arbiter: RTL and testbench

- Shares one AXI-style read-only system-memory port (AR and R channels only, same subset the L2 SMI drives) between NUM_MASTERS read clients, e.g. L2 SMI load path and a frame-buffer/DMA reader.
- Grants one whole burst at a time, selected by round-robin, and routes returned beats to the granted client.
- Sits between the clients' AXI read ports and the top-level memory interface.

---
 rtl/axi_read_arbiter_pkg.sv | 15 +
 rtl/axi_read_arbiter_rr_arbiter.sv | 51 +++++
 rtl/axi_read_arbiter.sv | 131 +++++++++++++
 tb/tb_axi_read_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the AXI read-port arbiter: bus widths and FSM state encoding.
// Build option AXI_READ_ARB_FIXED_PRIORITY_EN is honoured by the arbiter files, not here.
package axi_read_arbiter_pkg;

   localparam int AXI_DATA_WIDTH = 32;
   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_LEN_WIDTH  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter.sv
// Combinational request picker: round-robin after last_grant, or lowest index when
// AXI_READ_ARB_FIXED_PRIORITY_EN is defined (last_grant is then ignored).
module axi_read_arbiter_rr_arbiter
   import axi_read_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int GRANT_WIDTH = 1
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [GRANT_WIDTH-1:0] last_grant,
   output logic [NUM_MASTERS-1:0] grant,
   output logic [GRANT_WIDTH-1:0] grant_idx
);

   logic [NUM_MASTERS-1:0] pick_vec;

`ifdef AXI_READ_ARB_FIXED_PRIORITY_EN
   logic unused_last_grant;
   assign unused_last_grant = ^last_grant;
   assign pick_vec          = req;
`else
   // Requests above the previous winner take precedence; otherwise wrap to the bottom.
   logic [NUM_MASTERS-1:0] upper_mask;
   logic [NUM_MASTERS-1:0] upper_req;

   generate
      for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
         assign upper_mask[gi] = (GRANT_WIDTH'(gi) > last_grant);
      end
   endgenerate

   assign upper_req = req & upper_mask;
   assign pick_vec  = (|upper_req) ? upper_req : req;
`endif

   always_comb begin
      grant_idx = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (pick_vec[i]) begin
            grant_idx = GRANT_WIDTH'(i);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
         assign grant[gi] = pick_vec[gi] && (grant_idx == GRANT_WIDTH'(gi));
      end
   endgenerate

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read port (AR/R) between NUM_MASTERS clients, one whole burst per grant.
// Define AXI_READ_ARB_FIXED_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module axi_read_arbiter
   import axi_read_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int GRANT_WIDTH = 1
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [AXI_ADDR_WIDTH*NUM_MASTERS-1:0]  client_araddr,
   input  logic [AXI_LEN_WIDTH*NUM_MASTERS-1:0]   client_arlen,
   input  logic [NUM_MASTERS-1:0]                 client_arvalid,
   output logic [NUM_MASTERS-1:0]                 client_arready,
   input  logic [NUM_MASTERS-1:0]                 client_rready,
   output logic [NUM_MASTERS-1:0]                 client_rvalid,
   output logic [AXI_DATA_WIDTH-1:0]              client_rdata,
   output logic [AXI_ADDR_WIDTH-1:0]              axi_araddr,
   output logic [AXI_LEN_WIDTH-1:0]               axi_arlen,
   output logic                                   axi_arvalid,
   input  logic                                   axi_arready,
   input  logic                                   axi_rvalid,
   output logic                                   axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0]              axi_rdata
);

   arb_state_t                 state_reg;
   arb_state_t                 state_next;
   logic [GRANT_WIDTH-1:0]     grant_reg;
   logic [AXI_LEN_WIDTH-1:0]   beat_count_reg;
   logic [GRANT_WIDTH-1:0]     last_grant;
   logic [NUM_MASTERS-1:0]     arb_grant;
   logic [GRANT_WIDTH-1:0]     arb_idx;
   logic [NUM_MASTERS-1:0]     grant_sel;
   logic [AXI_ADDR_WIDTH-1:0]  client_addr [NUM_MASTERS];
   logic [AXI_LEN_WIDTH-1:0]   client_len  [NUM_MASTERS];
   logic                       rd_xfer;
   logic                       last_beat;

   generate
      for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_client
         assign client_addr[gi] = client_araddr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
         assign client_len[gi]  = client_arlen[gi*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
         assign grant_sel[gi]   = (grant_reg == GRANT_WIDTH'(gi));
      end
   endgenerate

   axi_read_arbiter_rr_arbiter #(
      .NUM_MASTERS (NUM_MASTERS),
      .GRANT_WIDTH (GRANT_WIDTH)
   ) u_rr_arbiter (
      .req        (client_arvalid),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .grant_idx  (arb_idx)
   );

   assign rd_xfer   = (state_reg == DATA) && axi_rvalid && axi_rready;
   assign last_beat = rd_xfer && (beat_count_reg == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (|arb_grant)  state_next = ADDR;
         ADDR:    if (axi_arready) state_next = DATA;
         DATA:    if (last_beat)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      axi_arvalid    = 1'b0;
      axi_rready     = 1'b0;
      client_arready = '0;
      client_rvalid  = '0;
      case (state_reg)
         ADDR: begin
            axi_arvalid    = 1'b1;
            client_arready = grant_sel & {NUM_MASTERS{axi_arready}};
         end
         DATA: begin
            axi_rready    = |(client_rready & grant_sel);
            client_rvalid = grant_sel & {NUM_MASTERS{axi_rvalid}};
         end
         default: ;
      endcase
   end

   // Address fields come straight from the winner; AXI requires clients to hold them.
   assign axi_araddr   = client_addr[grant_reg];
   assign axi_arlen    = client_len[grant_reg];
   assign client_rdata = axi_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_reg      <= '0;
         beat_count_reg <= '0;
      end else if ((state_reg == IDLE) && (|arb_grant)) begin
         grant_reg      <= arb_idx;
         beat_count_reg <= client_len[arb_idx];
      end else if (rd_xfer && (beat_count_reg != '0)) begin
         beat_count_reg <= beat_count_reg - 1'b1;
      end
   end

`ifdef AXI_READ_ARB_FIXED_PRIORITY_EN
   assign last_grant = '0;
`else
   logic [GRANT_WIDTH-1:0] last_grant_reg;

   // Starts at the top index so client 0 is first after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_reg <= GRANT_WIDTH'(NUM_MASTERS - 1);
      end else if (last_beat) begin
         last_grant_reg <= grant_reg;
      end
   end

   assign last_grant = last_grant_reg;
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: randomized traffic against a transaction-level model.
module tb_axi_read_arbiter;

   localparam int NM = 2;
   localparam int GW = 1;

   logic              clk = 1'b0;
   logic              reset;
   logic [32*NM-1:0]  client_araddr;
   logic [8*NM-1:0]   client_arlen;
   logic [NM-1:0]     client_arvalid;
   logic [NM-1:0]     client_arready;
   logic [NM-1:0]     client_rready;
   logic [NM-1:0]     client_rvalid;
   logic [31:0]       client_rdata;
   logic [31:0]       axi_araddr;
   logic [7:0]        axi_arlen;
   logic              axi_arvalid;
   logic              axi_arready;
   logic              axi_rvalid;
   logic              axi_rready;
   logic [31:0]       axi_rdata;

   int checks     = 0;
   int failures   = 0;
   int model_last = NM - 1;

   always #5 clk = ~clk;

   axi_read_arbiter #(
      .NUM_MASTERS (NM),
      .GRANT_WIDTH (GW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .client_araddr  (client_araddr),
      .client_arlen   (client_arlen),
      .client_arvalid (client_arvalid),
      .client_arready (client_arready),
      .client_rready  (client_rready),
      .client_rvalid  (client_rvalid),
      .client_rdata   (client_rdata),
      .axi_araddr     (axi_araddr),
      .axi_arlen      (axi_arlen),
      .axi_arvalid    (axi_arvalid),
      .axi_arready    (axi_arready),
      .axi_rvalid     (axi_rvalid),
      .axi_rready     (axi_rready),
      .axi_rdata      (axi_rdata)
   );

   // Which requesting client should win, given the model's memory of the last served one.
   function automatic int model_pick(input logic [NM-1:0] req);
`ifdef AXI_READ_ARB_FIXED_PRIORITY_EN
      for (int i = 0; i < NM; i++) if (req[i]) return i;
`else
      for (int k = 1; k <= NM; k++) begin
         int c;
         c = (model_last + k) % NM;
         if (req[c]) return c;
      end
`endif
      return -1;
   endfunction

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic set_client(input int c, input logic [31:0] a, input logic [7:0] l);
      client_araddr[32*c +: 32] = a;
      client_arlen[8*c +: 8]    = l;
      client_arvalid[c]         = 1'b1;
   endtask

   // Runs the address handshake with 'stall' cycles of arready low; reports what was seen.
   task automatic addr_phase(input int stall, output int granted, output logic [31:0] addr,
                             output logic [7:0] len, output int lag, output int held,
                             output int pulses, output int unstable);
      bit done;
      done = 0; granted = -1; addr = '0; len = '0;
      lag = 0; held = 0; pulses = 0; unstable = 0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         if (!axi_arvalid) begin
            axi_arready = 1'b0;
            #1;
            if (held == 0) lag++;
            if (client_arready !== '0) pulses++;
         end else begin
            if (held == 0) begin
               addr = axi_araddr;
               len  = axi_arlen;
            end else if (axi_araddr !== addr || axi_arlen !== len) begin
               unstable++;
            end
            axi_arready = (held >= stall);
            #1;
            if (client_arready !== '0) begin
               pulses++;
               granted = client_arready[1] ? 1 : 0;
            end
            held++;
            if (axi_arready) done = 1;
         end
         next_cycle();
      end
   endtask

   // Delivers n beats for client g; counts routing errors and any activity after the burst.
   task automatic data_phase(input int g, input int n, input bit rv_rand, input int rr_mode,
                             input bit check_end, output int xfers, output int cycles,
                             output int bad, output int extra);
      logic [NM-1:0] exp_rv;
      xfers = 0; cycles = 0; bad = 0; extra = 0;
      for (int cyc = 0; cyc < 3000 && xfers < n; cyc++) begin
         axi_arready   = 1'b0;
         axi_rvalid    = rv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         axi_rdata     = $urandom;
         client_rready = NM'($urandom);
         case (rr_mode)
            0:       client_rready[g] = 1'b1;
            2:       client_rready[g] = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: ;
         endcase
         #1;
         exp_rv = '0;
         if (axi_rvalid) exp_rv[g] = 1'b1;
         if (axi_rready !== client_rready[g]) bad++;
         if (client_rvalid !== exp_rv) bad++;
         if (client_rdata !== axi_rdata) bad++;
         if (client_arready !== '0 || axi_arvalid !== 1'b0) bad++;
         if (axi_rvalid && client_rready[g]) xfers++;
         cycles++;
         next_cycle();
      end
      if (check_end) begin
         axi_rvalid    = 1'b1;
         client_rready = '1;
         #1;
         if (axi_rready !== 1'b0 || client_rvalid !== '0 || axi_arvalid !== 1'b0) extra++;
         next_cycle();
      end
      axi_rvalid    = 1'b0;
      client_rready = '0;
   endtask

   task automatic test_reset();
      client_arvalid = '1;
      repeat (3) next_cycle();
      checks++;
      if ({axi_arvalid, axi_rready, client_arready, client_rvalid} !== 6'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected 000000",
                  {axi_arvalid, axi_rready, client_arready, client_rvalid});
      end
      client_arvalid = '0;
      reset          = 1'b1;
      model_last     = NM - 1;
      repeat (2) next_cycle();
      checks++;
      if ({axi_arvalid, axi_rready, client_arready, client_rvalid} !== 6'b0) begin
         failures++;
         $display("FAIL idle_outputs: got %b expected 000000",
                  {axi_arvalid, axi_rready, client_arready, client_rvalid});
      end
   endtask

   task automatic test_single();
      int g, lag, held, pulses, unst, xf, cyc, bad, extra, exp;
      logic [31:0] a;
      logic [7:0]  l;
      set_client(0, 32'h0000_1000, 8'd15);
      exp = model_pick(client_arvalid);
      addr_phase(0, g, a, l, lag, held, pulses, unst);
      client_arvalid[0] = 1'b0;
      checks++;
      if (lag !== 1) begin failures++; $display("FAIL single_lag: got %0d expected 1", lag); end
      checks++;
      if (g !== exp) begin failures++; $display("FAIL single_grant: got %0d expected %0d", g, exp); end
      checks++;
      if (a !== 32'h0000_1000 || l !== 8'd15) begin
         failures++;
         $display("FAIL single_addr: got %h/%0d expected 00001000/15", a, l);
      end
      checks++;
      if (pulses !== 1) begin failures++; $display("FAIL single_arready: got %0d pulses expected 1", pulses); end
      data_phase(exp, 16, 1'b1, 0, 1'b1, xf, cyc, bad, extra);
      checks++;
      if (xf !== 16) begin failures++; $display("FAIL single_beats: got %0d expected 16", xf); end
      checks++;
      if (bad + extra !== 0) begin
         failures++;
         $display("FAIL single_route: got %0d bad %0d extra expected 0", bad, extra);
      end
      model_last = exp;
      $display("txn single client=%0d addr=0x%08h len=%0d beats=%0d", exp, a, l, xf);
   endtask

   task automatic test_contention();
      int g, lag, held, pulses, unst, xf, cyc, bad, extra, exp;
      logic [31:0] a;
      logic [7:0]  l;
      set_client(0, $urandom, 8'd3);
      set_client(1, $urandom, 8'd3);
      for (int it = 0; it < 4; it++) begin
         exp = model_pick(client_arvalid);
         addr_phase(0, g, a, l, lag, held, pulses, unst);
         if (it == 3) client_arvalid = '0;
         checks++;
         if (g !== exp || a !== client_araddr[32*exp +: 32]) begin
            failures++;
            $display("FAIL contention_grant[%0d]: got client %0d addr %h expected client %0d addr %h",
                     it, g, a, exp, client_araddr[32*exp +: 32]);
         end
         checks++;
         if (lag !== ((it == 0) ? 1 : 0)) begin
            failures++;
            $display("FAIL contention_lag[%0d]: got %0d expected %0d", it, lag, (it == 0) ? 1 : 0);
         end
         data_phase(exp, 4, 1'b1, 1, 1'b1, xf, cyc, bad, extra);
         checks++;
         if (bad + extra !== 0) begin
            failures++;
            $display("FAIL contention_data[%0d]: got %0d bad %0d extra expected 0", it, bad, extra);
         end
         model_last = exp;
         $display("txn contention client=%0d addr=0x%08h len=%0d beats=%0d", exp, a, l, xf);
      end
   endtask

   task automatic test_backpressure();
      int g, lag, held, pulses, unst, xf, cyc, bad, extra, exp;
      logic [31:0] a;
      logic [7:0]  l;
      set_client(0, $urandom, 8'd3);
      exp = model_pick(client_arvalid);
      addr_phase(0, g, a, l, lag, held, pulses, unst);
      client_arvalid[0] = 1'b0;
      data_phase(exp, 4, 1'b0, 2, 1'b1, xf, cyc, bad, extra);
      checks++;
      if (cyc !== 8 || xf !== 4) begin
         failures++;
         $display("FAIL backpressure_len: got %0d beats in %0d cycles expected 4 in 8", xf, cyc);
      end
      checks++;
      if (bad + extra !== 0) begin
         failures++;
         $display("FAIL backpressure_data: got %0d bad %0d extra expected 0", bad, extra);
      end
      model_last = exp;
      $display("txn backpressure client=%0d addr=0x%08h len=%0d beats=%0d", exp, a, l, xf);
   endtask

   task automatic test_edge_lengths();
      int g, lag, held, pulses, unst, xf, cyc, bad, extra, exp;
      logic [31:0] a;
      logic [7:0]  l;
      logic [7:0]  lens [2];
      lens[0] = 8'd0;
      lens[1] = 8'd255;
      for (int k = 0; k < 2; k++) begin
         set_client(1 - k, $urandom, lens[k]);
         exp = model_pick(client_arvalid);
         addr_phase(0, g, a, l, lag, held, pulses, unst);
         client_arvalid = '0;
         checks++;
         if (g !== exp || l !== lens[k]) begin
            failures++;
            $display("FAIL edge_grant[%0d]: got client %0d len %0d expected client %0d len %0d",
                     k, g, l, exp, lens[k]);
         end
         data_phase(exp, int'(lens[k]) + 1, 1'b1, 0, 1'b1, xf, cyc, bad, extra);
         checks++;
         if (xf !== int'(lens[k]) + 1 || bad + extra !== 0) begin
            failures++;
            $display("FAIL edge_beats[%0d]: got %0d beats %0d bad %0d extra expected %0d beats",
                     k, xf, bad, extra, int'(lens[k]) + 1);
         end
         model_last = exp;
         $display("txn edge client=%0d addr=0x%08h len=%0d beats=%0d", exp, a, l, xf);
      end
   endtask

   task automatic test_addr_stall();
      int g, lag, held, pulses, unst, xf, cyc, bad, extra, exp;
      logic [31:0] a;
      logic [7:0]  l;
      logic [31:0] want_addr;
      want_addr = $urandom;
      set_client(1, want_addr, 8'd2);
      exp = model_pick(client_arvalid);
      addr_phase(5, g, a, l, lag, held, pulses, unst);
      client_arvalid = '0;
      checks++;
      if (held !== 6) begin failures++; $display("FAIL stall_arvalid: got %0d cycles expected 6", held); end
      checks++;
      if (pulses !== 1 || g !== exp) begin
         failures++;
         $display("FAIL stall_arready: got %0d pulses client %0d expected 1 pulse client %0d", pulses, g, exp);
      end
      checks++;
      if (unst !== 0 || a !== want_addr) begin
         failures++;
         $display("FAIL stall_addr: got %h (%0d changes) expected %h stable", a, unst, want_addr);
      end
      data_phase(exp, 3, 1'b1, 0, 1'b1, xf, cyc, bad, extra);
      checks++;
      if (bad + extra !== 0) begin
         failures++;
         $display("FAIL stall_data: got %0d bad %0d extra expected 0", bad, extra);
      end
      model_last = exp;
      $display("txn stall client=%0d addr=0x%08h len=%0d beats=%0d", exp, a, l, xf);
   endtask

   task automatic test_reset_midburst();
      int g, lag, held, pulses, unst, xf, cyc, bad, extra, exp;
      logic [31:0] a;
      logic [7:0]  l;
      set_client(0, $urandom, 8'd7);
      set_client(1, $urandom, 8'd7);
      exp = model_pick(client_arvalid);
      addr_phase(0, g, a, l, lag, held, pulses, unst);
      data_phase(exp, 2, 1'b0, 0, 1'b0, xf, cyc, bad, extra);
      axi_rvalid    = 1'b1;
      client_rready = '1;
      reset         = 1'b0;
      #1;
      checks++;
      if ({axi_arvalid, axi_rready, client_arready, client_rvalid} !== 6'b0) begin
         failures++;
         $display("FAIL midburst_reset: got %b expected 000000",
                  {axi_arvalid, axi_rready, client_arready, client_rvalid});
      end
      $display("txn reset_abandon client=%0d beats=%0d of 8", exp, xf);
      next_cycle();
      next_cycle();
      axi_rvalid    = 1'b0;
      client_rready = '0;
      reset         = 1'b1;
      model_last    = NM - 1;
      exp = model_pick(client_arvalid);
      addr_phase(0, g, a, l, lag, held, pulses, unst);
      client_arvalid = '0;
      checks++;
      if (g !== exp || lag !== 1) begin
         failures++;
         $display("FAIL post_reset_grant: got client %0d lag %0d expected client %0d lag 1", g, lag, exp);
      end
      data_phase(exp, 8, 1'b1, 1, 1'b1, xf, cyc, bad, extra);
      checks++;
      if (bad + extra !== 0) begin
         failures++;
         $display("FAIL post_reset_data: got %0d bad %0d extra expected 0", bad, extra);
      end
      model_last = exp;
      $display("txn post_reset client=%0d addr=0x%08h len=%0d beats=%0d", exp, a, l, xf);
   endtask

   task automatic test_random_traffic();
      int g, lag, held, pulses, unst, xf, cyc, bad, extra, exp;
      logic [31:0] a, exp_addr;
      logic [7:0]  l, exp_len;
      for (int it = 0; it < 25; it++) begin
         if (client_arvalid == '0) set_client($urandom_range(0, NM - 1), $urandom, 8'($urandom_range(0, 15)));
         exp      = model_pick(client_arvalid);
         exp_addr = client_araddr[32*exp +: 32];
         exp_len  = client_arlen[8*exp +: 8];
         addr_phase($urandom_range(0, 3), g, a, l, lag, held, pulses, unst);
         client_arvalid[exp] = 1'b0;
         // New requests arriving mid-burst must wait for the next arbitration.
         for (int c = 0; c < NM; c++) begin
            if (!client_arvalid[c] && $urandom_range(0, 1) == 1)
               set_client(c, $urandom, 8'($urandom_range(0, 15)));
         end
         checks++;
         if (g !== exp || a !== exp_addr || l !== exp_len || pulses !== 1 || unst !== 0) begin
            failures++;
            $display("FAIL random_addr[%0d]: got client %0d %h/%0d pulses %0d expected client %0d %h/%0d pulses 1",
                     it, g, a, l, pulses, exp, exp_addr, exp_len);
         end
         data_phase(exp, int'(exp_len) + 1, 1'b1, 1, 1'b1, xf, cyc, bad, extra);
         checks++;
         if (xf !== int'(exp_len) + 1 || bad + extra !== 0) begin
            failures++;
            $display("FAIL random_data[%0d]: got %0d beats %0d bad %0d extra expected %0d beats",
                     it, xf, bad, extra, int'(exp_len) + 1);
         end
         model_last = exp;
         $display("txn random client=%0d addr=0x%08h len=%0d beats=%0d", exp, a, l, xf);
      end
      client_arvalid = '0;
   endtask

   initial begin
      reset          = 1'b0;
      client_araddr  = '0;
      client_arlen   = '0;
      client_arvalid = '0;
      client_rready  = '0;
      axi_arready    = 1'b0;
      axi_rvalid     = 1'b0;
      axi_rdata      = '0;
      next_cycle();
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_edge_lengths();
      test_addr_stall();
      test_reset_midburst();
      test_random_traffic();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
